// File: rtl/bcd_stopwatch.sv
// Two-digit BCD stopwatch core: button conditioning, count prescaler, 00-99
// BCD counter and a time-multiplexed digit output for a 7-segment decoder.
module bcd_stopwatch #(
   parameter int TICK_DIV = 10_000_000,
   parameter int MUX_DIV  = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_clr,
   output logic [3:0] counter,
   output logic       digit_sel,
   output logic       running,
   output logic       wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   // Returns {carry, next_digit}; a digit at 9 (or corrupted above 9) rolls to 0.
   function automatic logic [4:0] bcd_inc(input logic [3:0] d);
      if (d >= 4'd9) begin
         bcd_inc = {1'b1, 4'd0};
      end else begin
         bcd_inc = {1'b0, d + 4'd1};
      end
   endfunction

   logic          run_meta_r;
   logic          run_sync_r;
   logic          run_dly_r;
   logic          clr_meta_r;
   logic          clr_sync_r;
   logic          run_edge_s;

   run_state_t    state_r;
   run_state_t    state_next_s;

   logic [PW-1:0] pre_r;
   logic [PW-1:0] pre_next_s;
   logic          tick_s;

   logic [3:0]    ones_r;
   logic [3:0]    tens_r;
   logic [3:0]    ones_next_s;
   logic [3:0]    tens_next_s;
   logic [4:0]    ones_inc_s;
   logic [4:0]    tens_inc_s;
   logic          wrap_r;
   logic          wrap_next_s;

   logic [MW-1:0] mux_r;
   logic [MW-1:0] mux_next_s;
   logic          sel_r;
   logic          sel_next_s;

   assign run_edge_s = run_sync_r & ~run_dly_r;
   assign tick_s     = (state_r == ST_RUN) && (pre_r == PRE_LAST);
   assign ones_inc_s = bcd_inc(ones_r);
   assign tens_inc_s = bcd_inc(tens_r);

   // Two-flop synchronizers for both buttons plus the run edge-detect delay flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_meta_r <= 1'b0;
         run_sync_r <= 1'b0;
         run_dly_r  <= 1'b0;
         clr_meta_r <= 1'b0;
         clr_sync_r <= 1'b0;
      end else begin
         run_meta_r <= btn_run;
         run_sync_r <= run_meta_r;
         run_dly_r  <= run_sync_r;
         clr_meta_r <= btn_clr;
         clr_sync_r <= clr_meta_r;
      end
   end

   // Run/stop state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_STOP;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Each synchronized rising edge of the run button flips between stop and run.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_STOP: begin
            if (run_edge_s) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_STOP;
            end
         end
         ST_RUN: begin
            if (run_edge_s) begin
               state_next_s = ST_STOP;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         default: state_next_s = ST_STOP;
      endcase
   end

   // Prescaler and BCD digits; clear beats tick, and the prescaler holds while stopped.
   always_comb begin
      pre_next_s  = pre_r;
      ones_next_s = ones_r;
      tens_next_s = tens_r;
      wrap_next_s = 1'b0;
      if (clr_sync_r) begin
         pre_next_s  = PW'(1'b0);
         ones_next_s = 4'd0;
         tens_next_s = 4'd0;
      end else begin
         if (state_r == ST_RUN) begin
            if (pre_r == PRE_LAST) begin
               pre_next_s = PW'(1'b0);
            end else begin
               pre_next_s = pre_r + PW'(1'b1);
            end
         end else begin
            pre_next_s = pre_r;
         end
         if (tick_s) begin
            ones_next_s = ones_inc_s[3:0];
            if (ones_inc_s[4]) begin
               tens_next_s = tens_inc_s[3:0];
               wrap_next_s = tens_inc_s[4];
            end else begin
               tens_next_s = tens_r;
            end
         end else begin
            ones_next_s = ones_r;
            tens_next_s = tens_r;
         end
      end
   end

   // Count state and the registered rollover pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_r  <= PW'(1'b0);
         ones_r <= 4'd0;
         tens_r <= 4'd0;
         wrap_r <= 1'b0;
      end else begin
         pre_r  <= pre_next_s;
         ones_r <= ones_next_s;
         tens_r <= tens_next_s;
         wrap_r <= wrap_next_s;
      end
   end

   // Free-running display mux divider; digit_sel flips each time it rolls over.
   always_comb begin
      if (mux_r == MUX_LAST) begin
         mux_next_s = MW'(1'b0);
         sel_next_s = ~sel_r;
      end else begin
         mux_next_s = mux_r + MW'(1'b1);
         sel_next_s = sel_r;
      end
   end

   // Display mux state.
   always_ff @(posedge clk) begin
      if (rst) begin
         mux_r <= MW'(1'b0);
         sel_r <= 1'b0;
      end else begin
         mux_r <= mux_next_s;
         sel_r <= sel_next_s;
      end
   end

   // Digit selection straight from registered state, so counter always tracks digit_sel.
   always_comb begin
      if (sel_r) begin
         counter = tens_r;
      end else begin
         counter = ones_r;
      end
   end

   assign digit_sel = sel_r;
   assign running   = (state_r == ST_RUN);
   assign wrap      = wrap_r;

endmodule
